// File: rtl/seg_check_arbiter_pkg.sv
// Shared definitions for the segment-check arbiter: FSM states, segment
// selects and requester ownership codes.
package seg_check_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [2:0] SEG_ES = 3'd0;
   localparam logic [2:0] SEG_CS = 3'd1;
   localparam logic [2:0] SEG_SS = 3'd2;
   localparam logic [2:0] SEG_DS = 3'd3;
   localparam logic [2:0] SEG_FS = 3'd4;
   localparam logic [2:0] SEG_GS = 3'd5;

   localparam logic OWNER_R0 = 1'b0;
   localparam logic OWNER_R1 = 1'b1;

endpackage

// File: rtl/seg_check_arbiter_prio.sv
// Grant selection between the read stage (r0) and the write pre-check (r1),
// with a starvation counter that forces r1 after STARVE_MAX r0 wins.
module seg_check_prio #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic i_idle,
   input  logic i_r0_valid,
   input  logic i_r1_valid,
   output logic o_grant0,
   output logic o_grant1
);
   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] r_cnt;
   logic             w_en;
   logic             w_starved;

   assign w_en      = i_idle & ~flush & ~rst;
   assign w_starved = i_r1_valid & (r_cnt == LP_MAX);
   assign o_grant0  = w_en & i_r0_valid & ~w_starved;
   assign o_grant1  = w_en & i_r1_valid & (~i_r0_valid | w_starved);

   // Count only r0 wins that actually made r1 wait; any idle cycle without r1 resets it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_cnt <= '0;
      end else if (o_grant1 || (i_idle && !i_r1_valid)) begin
         r_cnt <= '0;
      end else if (o_grant0 && i_r1_valid && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg_check_arbiter.sv
// Arbitrates the shared segment-check datapath between the read stage and the
// write pre-check, issuing one evaluate cycle and holding the result until ack.
//
//   state | meaning
//   IDLE  | waiting for a request; ready is offered to the winner
//   CHECK | latched request driven into the datapath for one cycle
//   RESP  | captured result held for the owner until resp_ack
module seg_check_arbiter
   import seg_check_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [31:0] r0_address,
   input  logic [3:0]  r0_length,
   input  logic [2:0]  r0_seg,
   input  logic        r0_rmw,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [31:0] r1_address,
   input  logic [3:0]  r1_length,
   input  logic [2:0]  r1_seg,
   output logic [31:0] chk_address_effective,
   output logic        chk_address_effective_ready,
   output logic [3:0]  chk_read_length,
   output logic [2:0]  chk_seg,
   output logic        chk_read_virtual,
   output logic        chk_read_rmw_virtual,
   output logic        chk_write_virtual_check,
   input  logic        chk_gp_fault,
   input  logic        chk_ss_fault,
   input  logic [31:0] chk_linear,
   output logic        resp_valid,
   output logic        resp_owner,
   output logic [31:0] resp_linear,
   output logic        resp_gp,
   output logic        resp_ss,
   input  logic        resp_ack
);
   state_t      r_state;
   logic        r_owner;
   logic [31:0] r_addr;
   logic [3:0]  r_len;
   logic [2:0]  r_seg;
   logic        r_chk_strobe;
   logic        r_rd_v;
   logic        r_rmw_v;
   logic        r_wr_v;
   logic [31:0] r_linear;
   logic        r_gp;
   logic        r_ss;
   logic        w_idle;
   logic        w_grant0;
   logic        w_grant1;

   assign w_idle = (r_state == ST_IDLE);

   seg_check_prio #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_prio (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .i_idle     (w_idle),
      .i_r0_valid (r0_valid),
      .i_r1_valid (r1_valid),
      .o_grant0   (w_grant0),
      .o_grant1   (w_grant1)
   );

   // Kind strobes are set on accept so they are high exactly for the CHECK cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWNER_R0;
         r_addr       <= '0;
         r_len        <= '0;
         r_seg        <= '0;
         r_chk_strobe <= 1'b0;
         r_rd_v       <= 1'b0;
         r_rmw_v      <= 1'b0;
         r_wr_v       <= 1'b0;
         r_linear     <= '0;
         r_gp         <= 1'b0;
         r_ss         <= 1'b0;
      end else begin
         r_chk_strobe <= 1'b0;
         r_rd_v       <= 1'b0;
         r_rmw_v      <= 1'b0;
         r_wr_v       <= 1'b0;
         if (flush) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_grant0) begin
                     r_owner      <= OWNER_R0;
                     r_addr       <= r0_address;
                     r_len        <= r0_length;
                     r_seg        <= r0_seg;
                     r_chk_strobe <= 1'b1;
                     r_rd_v       <= ~r0_rmw;
                     r_rmw_v      <= r0_rmw;
                     r_state      <= ST_CHECK;
                  end else if (w_grant1) begin
                     r_owner      <= OWNER_R1;
                     r_addr       <= r1_address;
                     r_len        <= r1_length;
                     r_seg        <= r1_seg;
                     r_chk_strobe <= 1'b1;
                     r_wr_v       <= 1'b1;
                     r_state      <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  r_linear <= chk_linear;
                  r_gp     <= chk_gp_fault;
                  r_ss     <= chk_ss_fault;
                  r_state  <= ST_RESP;
               end
               ST_RESP: begin
                  if (resp_ack) r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign r0_ready                    = w_grant0;
   assign r1_ready                    = w_grant1;
   assign chk_address_effective       = r_addr;
   assign chk_address_effective_ready = r_chk_strobe;
   assign chk_read_length             = r_len;
   assign chk_seg                     = r_seg;
   assign chk_read_virtual            = r_rd_v;
   assign chk_read_rmw_virtual        = r_rmw_v;
   assign chk_write_virtual_check     = r_wr_v;
   assign resp_valid                  = (r_state == ST_RESP);
   assign resp_owner                  = r_owner;
   assign resp_linear                 = r_linear;
   assign resp_gp                     = r_gp;
   assign resp_ss                     = r_ss;

endmodule

// File: tb/tb_seg_check_arbiter.sv
// Bench for seg_check_arbiter: directed scenarios plus random traffic against
// a transaction-level model of grant order, datapath results and timing.
module tb_seg_check_arbiter;
   import seg_check_arbiter_pkg::*;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        r0_valid = 1'b0, r0_ready, r0_rmw = 1'b0;
   logic [31:0] r0_address = '0;
   logic [3:0]  r0_length = '0;
   logic [2:0]  r0_seg = '0;
   logic        r1_valid = 1'b0, r1_ready;
   logic [31:0] r1_address = '0;
   logic [3:0]  r1_length = '0;
   logic [2:0]  r1_seg = '0;
   logic [31:0] chk_address_effective;
   logic        chk_address_effective_ready;
   logic [3:0]  chk_read_length;
   logic [2:0]  chk_seg;
   logic        chk_read_virtual, chk_read_rmw_virtual, chk_write_virtual_check;
   logic        chk_gp_fault, chk_ss_fault;
   logic [31:0] chk_linear;
   logic        resp_valid, resp_owner, resp_gp, resp_ss;
   logic [31:0] resp_linear;
   logic        resp_ack = 1'b0;

   int total = 0;
   int bad   = 0;
   int starve = 0;

   logic        e_owner;
   logic [31:0] e_addr;
   logic [3:0]  e_len;
   logic [2:0]  e_seg;
   logic        e_rmw;

   always #5 clk = ~clk;

   seg_check_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_address(r0_address),
      .r0_length(r0_length), .r0_seg(r0_seg), .r0_rmw(r0_rmw),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_address(r1_address),
      .r1_length(r1_length), .r1_seg(r1_seg),
      .chk_address_effective(chk_address_effective),
      .chk_address_effective_ready(chk_address_effective_ready),
      .chk_read_length(chk_read_length), .chk_seg(chk_seg),
      .chk_read_virtual(chk_read_virtual), .chk_read_rmw_virtual(chk_read_rmw_virtual),
      .chk_write_virtual_check(chk_write_virtual_check),
      .chk_gp_fault(chk_gp_fault), .chk_ss_fault(chk_ss_fault), .chk_linear(chk_linear),
      .resp_valid(resp_valid), .resp_owner(resp_owner), .resp_linear(resp_linear),
      .resp_gp(resp_gp), .resp_ss(resp_ss), .resp_ack(resp_ack)
   );

   // Datapath stand-in: segment base table, faults on addresses in the top 256 MiB.
   function automatic logic [31:0] seg_base(input logic [2:0] s);
      case (s)
         3'd0:    return 32'h0000_0000;
         3'd1:    return 32'h0001_0000;
         3'd2:    return 32'h0000_8000;
         3'd3:    return 32'h0002_0000;
         3'd4:    return 32'h0003_0000;
         3'd5:    return 32'h0004_0000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   assign chk_linear   = chk_address_effective_ready ? seg_base(chk_seg) + chk_address_effective : 32'h0;
   assign chk_ss_fault = chk_address_effective_ready && (chk_address_effective[31:28] == 4'hF) && (chk_seg == SEG_SS);
   assign chk_gp_fault = chk_address_effective_ready && (chk_address_effective[31:28] == 4'hF) && (chk_seg != SEG_SS);

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_r0(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s, input logic m);
      r0_valid = 1'b1; r0_address = a; r0_length = l; r0_seg = s; r0_rmw = m;
   endtask

   task automatic set_r1(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
      r1_valid = 1'b1; r1_address = a; r1_length = l; r1_seg = s;
   endtask

   task automatic scramble();
      r0_valid   = 1'($urandom_range(0, 1));
      r1_valid   = 1'($urandom_range(0, 1));
      r0_address = $urandom;
      r1_address = $urandom;
      r0_length  = 4'($urandom_range(1, 8));
      r1_length  = 4'($urandom_range(1, 8));
      r0_seg     = 3'($urandom_range(0, 5));
      r1_seg     = 3'($urandom_range(0, 5));
      r0_rmw     = 1'($urandom_range(0, 1));
   endtask

   // Called with inputs already driven for an IDLE cycle; predicts the winner.
   task automatic idle_step(output bit acc);
      int win;
      #1;
      win = 0;
      if (r0_valid) win = (r1_valid && starve == STARVE_MAX) ? 2 : 1;
      else if (r1_valid) win = 2;
      chk1("idle_r0_ready", r0_ready, win == 1);
      chk1("idle_r1_ready", r1_ready, win == 2);
      chk1("idle_resp_valid", resp_valid, 1'b0);
      chk1("idle_chk_strobe", chk_address_effective_ready, 1'b0);
      chk1("idle_kinds", chk_read_virtual | chk_read_rmw_virtual | chk_write_virtual_check, 1'b0);
      if (win == 1 && r1_valid) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
      else if (win == 2 || !r1_valid) starve = 0;
      if (win == 1) begin
         e_owner = 1'b0; e_addr = r0_address; e_len = r0_length; e_seg = r0_seg; e_rmw = r0_rmw;
      end else if (win == 2) begin
         e_owner = 1'b1; e_addr = r1_address; e_len = r1_length; e_seg = r1_seg; e_rmw = 1'b0;
      end
      acc = (win != 0);
   endtask

   // CHECK cycle, then RESP held for ack_delay extra cycles, ack in the last one.
   task automatic serve(input int ack_delay);
      logic [31:0] x_lin;
      logic        x_hi, x_gp, x_ss;
      x_lin = seg_base(e_seg) + e_addr;
      x_hi  = (e_addr[31:28] == 4'hF);
      x_ss  = x_hi && (e_seg == SEG_SS);
      x_gp  = x_hi && (e_seg != SEG_SS);
      @(negedge clk);
      resp_ack = 1'b0;
      scramble();
      #1;
      chk1("check_strobe", chk_address_effective_ready, 1'b1);
      chk32("check_addr", chk_address_effective, e_addr);
      chk32("check_len", 32'(chk_read_length), 32'(e_len));
      chk32("check_seg", 32'(chk_seg), 32'(e_seg));
      chk1("check_read", chk_read_virtual, !e_owner && !e_rmw);
      chk1("check_rmw", chk_read_rmw_virtual, !e_owner && e_rmw);
      chk1("check_write", chk_write_virtual_check, e_owner);
      chk1("check_rdy", r0_ready | r1_ready, 1'b0);
      chk1("check_resp_valid", resp_valid, 1'b0);
      for (int k = 0; k <= ack_delay; k++) begin
         @(negedge clk);
         resp_ack = (k == ack_delay);
         scramble();
         #1;
         chk1("resp_valid", resp_valid, 1'b1);
         chk1("resp_owner", resp_owner, e_owner);
         chk32("resp_linear", resp_linear, x_lin);
         chk1("resp_gp", resp_gp, x_gp);
         chk1("resp_ss", resp_ss, x_ss);
         chk1("resp_gp_ss_excl", resp_gp & resp_ss, 1'b0);
         chk1("resp_strobe", chk_address_effective_ready, 1'b0);
         chk1("resp_kinds", chk_read_virtual | chk_read_rmw_virtual | chk_write_virtual_check, 1'b0);
         chk1("resp_rdy", r0_ready | r1_ready, 1'b0);
         chk32("resp_chk_addr_held", chk_address_effective, e_addr);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      // Reset with requests presented: everything must read 0.
      set_r0(32'h1234, 4'd4, 3'd1, 1'b1);
      set_r1(32'h5678, 4'd2, 3'd2);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk1("rst_r0_ready", r0_ready, 1'b0);
      chk1("rst_r1_ready", r1_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk32("rst_resp_linear", resp_linear, 32'h0);
      chk32("rst_chk_addr", chk_address_effective, 32'h0);
      chk1("rst_chk_strobe", chk_address_effective_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      starve = 0;

      // Single plain read through DS.
      @(negedge clk);
      set_r0(32'h0000_1000, 4'd4, SEG_DS, 1'b0);
      idle_step(acc);
      chk1("single_acc", acc, 1'b1);
      serve(1);
      @(negedge clk);
      resp_ack = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      chk1("single_resp_drop", resp_valid, 1'b0);
      chk32("single_linear_const", resp_linear, 32'h0002_1000);

      // Starvation: both requesters always valid, immediate ack.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         resp_ack = 1'b0;
         set_r0(32'h100 * i, 4'd1, SEG_DS, 1'b0);
         set_r1(32'h8000 + i, 4'd2, SEG_GS);
         idle_step(acc);
         chk1("starve_acc", acc, 1'b1);
         chk1("starve_r1_ready", r1_ready, (i % 5) == 4);
         serve(0);
      end

      // Write pre-check on SS that faults, result held for 5 cycles.
      @(negedge clk);
      resp_ack = 1'b0; r0_valid = 1'b0;
      set_r1(32'hF000_0010, 4'd2, SEG_SS);
      idle_step(acc);
      chk1("fault_acc", acc, 1'b1);
      serve(5);

      // RMW decode.
      @(negedge clk);
      resp_ack = 1'b0; r1_valid = 1'b0;
      set_r0(32'h0000_4444, 4'd8, SEG_ES, 1'b1);
      idle_step(acc);
      chk1("rmw_acc", acc, 1'b1);
      serve(2);

      // Flush during CHECK discards the result; next request accepted after.
      @(negedge clk);
      resp_ack = 1'b0; r1_valid = 1'b0;
      set_r0(32'h0000_2000, 4'd8, SEG_CS, 1'b0);
      idle_step(acc);
      chk1("flushc_acc", acc, 1'b1);
      @(negedge clk);
      flush = 1'b1; r0_valid = 1'b0;
      #1;
      chk1("flushc_strobe", chk_address_effective_ready, 1'b1);
      starve = 0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk1("flushc_resp_valid", resp_valid, 1'b0);
      chk1("flushc_idle_strobe", chk_address_effective_ready, 1'b0);
      @(negedge clk);
      set_r0(32'h0000_3000, 4'd1, SEG_FS, 1'b0);
      idle_step(acc);
      chk1("flushc_next_acc", acc, 1'b1);
      serve(0);

      // Flush in IDLE with both requesters pending.
      @(negedge clk);
      resp_ack = 1'b0; flush = 1'b1;
      set_r0(32'h0000_0AA0, 4'd4, SEG_DS, 1'b0);
      set_r1(32'h0000_0BB0, 4'd4, SEG_ES);
      #1;
      chk1("flushi_r0_ready", r0_ready, 1'b0);
      chk1("flushi_r1_ready", r1_ready, 1'b0);
      starve = 0;
      @(negedge clk);
      flush = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      chk1("flushi_no_accept", chk_address_effective_ready, 1'b0);

      // Flush together with ack in RESP.
      @(negedge clk);
      set_r1(32'h0000_0500, 4'd4, SEG_CS);
      idle_step(acc);
      chk1("flushr_acc", acc, 1'b1);
      @(negedge clk);
      r1_valid = 1'b0;
      #1;
      chk1("flushr_strobe", chk_address_effective_ready, 1'b1);
      @(negedge clk);
      flush = 1'b1; resp_ack = 1'b1;
      #1;
      chk1("flushr_resp_valid", resp_valid, 1'b1);
      starve = 0;
      @(negedge clk);
      flush = 1'b0; resp_ack = 1'b0;
      #1;
      chk1("flushr_after", resp_valid, 1'b0);

      // Reset in the middle of RESP.
      @(negedge clk);
      set_r1(32'hF000_0100, 4'd4, SEG_FS);
      idle_step(acc);
      chk1("rstr_acc", acc, 1'b1);
      @(negedge clk);
      r1_valid = 1'b0;
      @(negedge clk);
      #1;
      chk1("rstr_resp_valid", resp_valid, 1'b1);
      chk1("rstr_resp_gp", resp_gp, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      starve = 0;
      chk1("rstr_resp_valid0", resp_valid, 1'b0);
      chk1("rstr_owner0", resp_owner, 1'b0);
      chk1("rstr_gp0", resp_gp, 1'b0);
      chk32("rstr_linear0", resp_linear, 32'h0);
      chk32("rstr_chk_addr0", chk_address_effective, 32'h0);
      chk32("rstr_chk_len0", 32'(chk_read_length), 32'h0);
      chk32("rstr_chk_seg0", 32'(chk_seg), 32'h0);
      chk1("rstr_kinds0", chk_read_virtual | chk_read_rmw_virtual | chk_write_virtual_check, 1'b0);

      // Random traffic, including acks that arrive outside RESP.
      for (int t = 0; t < 40; t++) begin
         acc = 1'b0;
         for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk);
            resp_ack   = 1'($urandom_range(0, 1));
            r0_valid   = ($urandom_range(0, 3) != 0);
            r1_valid   = ($urandom_range(0, 3) != 0);
            r0_address = ($urandom & 32'h0FFF_FFFF) | (($urandom_range(0, 3) == 0) ? 32'hF000_0000 : 32'h0);
            r1_address = ($urandom & 32'h0FFF_FFFF) | (($urandom_range(0, 3) == 0) ? 32'hF000_0000 : 32'h0);
            r0_length  = 4'($urandom_range(1, 8));
            r1_length  = 4'($urandom_range(1, 8));
            r0_seg     = 3'($urandom_range(0, 5));
            r1_seg     = 3'($urandom_range(0, 5));
            r0_rmw     = 1'($urandom_range(0, 1));
            idle_step(acc);
         end
         if (acc) serve(int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      resp_ack = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      chk1("final_idle", resp_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
